// File: rtl/adder_pkg.sv
// Shared types and the stage-0 arithmetic for the pipelined add/subtract unit.
package adder_pkg;

    // Widest operand the shared arithmetic function supports.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Result record sized to MAX_WIDTH; instantiating modules narrow the sum.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic                 carry;
        logic                 ovf;
    } add_res_t;

    // Add or subtract at width+1 bits, derive carry/overflow from the raw
    // operation, then optionally clamp. Bits at and above 'width' are ignored
    // on input and returned as zero.
    function automatic add_res_t add_sat(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input op_e                  op,
        input logic                 signed_,
        input logic                 sat_en,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] pos_max;
        logic [MAX_WIDTH-1:0] msb_mask;
        logic [MAX_WIDTH-1:0] am;
        logic [MAX_WIDTH-1:0] bp;
        logic [MAX_WIDTH-1:0] s;
        logic [MAX_WIDTH:0]   full;
        logic [MAX_WIDTH:0]   carry_mask;
        logic                 a_msb;
        logic                 b_msb;
        logic                 s_msb;
        add_res_t             r;

        mask       = '1;
        mask       = mask >> (MAX_WIDTH - width);
        pos_max    = mask >> 1;
        msb_mask   = mask & ~pos_max;
        am         = a & mask;
        bp         = (op == OP_SUB) ? (~b & mask) : (b & mask);
        full       = {1'b0, am} + {1'b0, bp} + {{MAX_WIDTH{1'b0}}, op == OP_SUB};
        carry_mask = {1'b0, mask} + {{MAX_WIDTH{1'b0}}, 1'b1};
        s          = full[MAX_WIDTH-1:0] & mask;

        // MSBs picked by masking so the bit position can follow 'width'.
        a_msb = |(am & msb_mask);
        b_msb = |(bp & msb_mask);
        s_msb = |(s & msb_mask);

        r.carry = |(full & carry_mask);
        r.ovf   = (a_msb == b_msb) && (s_msb != a_msb);
        r.sum   = s;

        if (sat_en) begin
            if (signed_) begin
                if (r.ovf) begin
                    r.sum = a_msb ? msb_mask : pos_max;
                end
            end else if (op == OP_ADD && r.carry) begin
                r.sum = mask;
            end else if (op == OP_SUB && !r.carry) begin
                r.sum = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One valid/ready register slice; holds its contents while downstream stalls.
module adder_pipe_stage #(
    parameter type data_t = logic
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  up_valid,
    output logic  up_ready,
    input  data_t up_data,
    output logic  dn_valid,
    input  logic  dn_ready,
    output data_t dn_data
);

    // Slice can take new data when empty or when its content leaves this cycle.
    always_comb begin
        up_ready = !dn_valid || dn_ready;
    end

    // Valid follows the upstream offer on every load; data only on real transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit with optional saturation and valid/ready on both sides.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int SAT_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } res_t;

    add_res_t          full;
    res_t              res0;
    logic              unused_hi;
    logic [STAGES-1:0] vq;
    logic [STAGES-1:0] acc;
    logic              unused_acc;
    res_t              dq [STAGES];

    // Stage-0 arithmetic, narrowed to the configured width.
    always_comb begin
        full       = add_sat(MAX_WIDTH'(in_a), MAX_WIDTH'(in_b), op_e'(in_op),
                             in_signed, SAT_EN != 0, WIDTH);
        res0.sum   = full.sum[WIDTH-1:0];
        res0.carry = full.carry;
        res0.ovf   = full.ovf;
    end

    // Upper sum bits are always zero at this width.
    always_comb begin
        unused_hi = ^(full.sum >> WIDTH);
    end

    // Each stage's downstream ready is computed directly from the valid bits
    // of the later stages (flattened form of the ready chain) so no
    // combinational signal depends on itself.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic dn_rdy;

        if (k == STAGES - 1) begin : g_last
            // Last slice drains straight into the consumer.
            always_comb begin
                dn_rdy = out_ready;
            end
        end else begin : g_mid
            // Any empty slice further down lets everything above it advance.
            always_comb begin
                dn_rdy = out_ready || !(&vq[STAGES-1:k+1]);
            end
        end

        if (k == 0) begin : g_first
            adder_pipe_stage #(.data_t(res_t)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .up_valid (in_valid),
                .up_ready (acc[k]),
                .up_data  (res0),
                .dn_valid (vq[k]),
                .dn_ready (dn_rdy),
                .dn_data  (dq[k])
            );
        end else begin : g_next
            adder_pipe_stage #(.data_t(res_t)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .up_valid (vq[k-1]),
                .up_ready (acc[k]),
                .up_data  (dq[k-1]),
                .dn_valid (vq[k]),
                .dn_ready (dn_rdy),
                .dn_data  (dq[k])
            );
        end
    end

    // Later slices' ready outputs duplicate g_stage[k-1].dn_rdy.
    always_comb begin
        unused_acc = ^acc[STAGES-1:0];
    end

    // Output side and status; in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready  = acc[0] && !rst;
        out_valid = vq[STAGES-1];
        out_sum   = dq[STAGES-1].sum;
        out_carry = dq[STAGES-1].carry;
        out_ovf   = dq[STAGES-1].ovf;
        busy      = |vq;
    end

endmodule
